// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - ALU opcode encoding and register constants shared by the CPU datapath
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_LW   = 4'd2,
    ALU_SW   = 4'd3,
    ALU_ADDU = 4'd4,
    ALU_SUBU = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_BLEZ = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SRAV = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_SLTU = 4'd11,
    ALU_SLL  = 4'd12,
    ALU_SMUL = 4'd13,
    ALU_BGTZ = 4'd14
  } alu_op_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - picks the newest value of one source register from EX/MEM, MEM/WB or the register file
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic          exm_reg_write_i,
  input  logic [AW-1:0] exm_rd_i,
  input  logic [DW-1:0] exm_result_i,
  input  logic          mwb_reg_write_i,
  input  logic [AW-1:0] mwb_rd_i,
  input  logic [DW-1:0] mwb_result_i,
  output logic [DW-1:0] data_o
);

  logic exm_hit;
  logic mwb_hit;

  // EX/MEM is younger than MEM/WB, so it is checked first
  always_comb begin
    exm_hit = exm_reg_write_i && (exm_rd_i != AW'(REG_ZERO)) && (exm_rd_i == addr_i);
    mwb_hit = mwb_reg_write_i && (mwb_rd_i != AW'(REG_ZERO)) && (mwb_rd_i == addr_i);
    data_o  = rf_data_i;
    if (exm_hit) begin
      data_o = exm_result_i;
    end else if (mwb_hit) begin
      data_o = mwb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand forwarding and load-use stall
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs_addr_i,
  input  logic [AW-1:0] id_rt_addr_i,
  input  logic [AW-1:0] id_rd_addr_i,
  input  logic          id_rt_used_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [3:0]    id_alu_ctrl_i,
  input  logic          id_alu_src_i,
  input  logic          id_shift_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic          id_mem_write_i,
  input  logic          exm_reg_write_i,
  input  logic [AW-1:0] exm_rd_i,
  input  logic [DW-1:0] exm_result_i,
  input  logic          mwb_reg_write_i,
  input  logic [AW-1:0] mwb_rd_i,
  input  logic [DW-1:0] mwb_result_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          ex_valid_o,
  output logic [DW-1:0] ex_src1_o,
  output logic [DW-1:0] ex_src2_o,
  output logic [3:0]    ex_ctrl_o,
  output logic [DW-1:0] ex_store_data_o,
  output logic [AW-1:0] ex_rd_o,
  output logic          ex_reg_write_o,
  output logic          ex_mem_read_o,
  output logic          ex_mem_write_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
  logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          alu_src_q, alu_src_d, shift_q, shift_d;
  logic          reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [DW-1:0] rs_fwd, rt_fwd;

  always_comb begin
    stall_o = valid_q && mem_read_q && (rd_addr_q != AW'(REG_ZERO)) && id_valid_i && !flush_i &&
              ((rd_addr_q == id_rs_addr_i) || (id_rt_used_i && (rd_addr_q == id_rt_addr_i)));

    valid_d     = id_valid_i;
    rs_addr_d   = id_rs_addr_i;
    rt_addr_d   = id_rt_addr_i;
    rd_addr_d   = id_rd_addr_i;
    rs_data_d   = id_rs_data_i;
    rt_data_d   = id_rt_data_i;
    imm_d       = id_imm_i;
    ctrl_d      = id_alu_ctrl_i;
    alu_src_d   = id_alu_src_i;
    shift_d     = id_shift_i;
    reg_write_d = id_reg_write_i;
    mem_read_d  = id_mem_read_i;
    mem_write_d = id_mem_write_i;

    // Bubble: zeroed slot, so its addresses also can never match a forwarding source
    if (flush_i || stall_o) begin
      valid_d     = 1'b0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rd_addr_d   = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      ctrl_d      = ALU_AND;
      alu_src_d   = 1'b0;
      shift_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      ctrl_q      <= ALU_AND;
      alu_src_q   <= 1'b0;
      shift_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      alu_src_q   <= alu_src_d;
      shift_q     <= shift_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  fwd_sel #(.DW(DW), .AW(AW)) u_fwd_rs (
    .addr_i          (rs_addr_q),
    .rf_data_i       (rs_data_q),
    .exm_reg_write_i (exm_reg_write_i),
    .exm_rd_i        (exm_rd_i),
    .exm_result_i    (exm_result_i),
    .mwb_reg_write_i (mwb_reg_write_i),
    .mwb_rd_i        (mwb_rd_i),
    .mwb_result_i    (mwb_result_i),
    .data_o          (rs_fwd)
  );

  fwd_sel #(.DW(DW), .AW(AW)) u_fwd_rt (
    .addr_i          (rt_addr_q),
    .rf_data_i       (rt_data_q),
    .exm_reg_write_i (exm_reg_write_i),
    .exm_rd_i        (exm_rd_i),
    .exm_result_i    (exm_result_i),
    .mwb_reg_write_i (mwb_reg_write_i),
    .mwb_rd_i        (mwb_rd_i),
    .mwb_result_i    (mwb_result_i),
    .data_o          (rt_fwd)
  );

  always_comb begin
    ex_valid_o      = valid_q;
    ex_src1_o       = shift_q ? imm_q : rs_fwd;
    ex_src2_o       = alu_src_q ? imm_q : rt_fwd;
    ex_ctrl_o       = ctrl_q;
    ex_store_data_o = rt_fwd;
    ex_rd_o         = rd_addr_q;
    ex_reg_write_o  = reg_write_q && valid_q;
    ex_mem_read_o   = mem_read_q && valid_q;
    ex_mem_write_o  = mem_write_q && valid_q;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - randomized and directed checks of ex_operand_stage against a slot model
module tb_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rt_used, id_alu_src, id_shift, id_reg_write, id_mem_read, id_mem_write;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]    id_ctrl;
  logic          exm_wr, mwb_wr, flush;
  logic [AW-1:0] exm_rd, mwb_rd;
  logic [DW-1:0] exm_res, mwb_res;
  logic          stall, ex_valid, ex_rw, ex_mr, ex_mw;
  logic [DW-1:0] ex_src1, ex_src2, ex_store;
  logic [3:0]    ex_ctrl;
  logic [AW-1:0] ex_rd;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [3:0]    ctrl;
    logic          alu_src, shift, rw, mr, mw;
  } slot_t;

  slot_t m;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt), .id_rd_addr_i(id_rd),
    .id_rt_used_i(id_rt_used), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
    .id_imm_i(id_imm), .id_alu_ctrl_i(id_ctrl), .id_alu_src_i(id_alu_src), .id_shift_i(id_shift),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write),
    .exm_reg_write_i(exm_wr), .exm_rd_i(exm_rd), .exm_result_i(exm_res),
    .mwb_reg_write_i(mwb_wr), .mwb_rd_i(mwb_rd), .mwb_result_i(mwb_res),
    .flush_i(flush), .stall_o(stall), .ex_valid_o(ex_valid),
    .ex_src1_o(ex_src1), .ex_src2_o(ex_src2), .ex_ctrl_o(ex_ctrl),
    .ex_store_data_o(ex_store), .ex_rd_o(ex_rd),
    .ex_reg_write_o(ex_rw), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    if (exm_wr && exm_rd != 0 && exm_rd == a) return exm_res;
    if (mwb_wr && mwb_rd != 0 && mwb_rd == a) return mwb_res;
    return rf;
  endfunction

  function automatic logic model_stall();
    return m.valid && m.mr && m.rd != 0 && id_valid && !flush &&
           (m.rd == id_rs || (id_rt_used && m.rd == id_rt));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m = '0;
    else if (flush || model_stall()) m = '0;
    else m = '{id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_ctrl,
               id_alu_src, id_shift, id_reg_write, id_mem_read, id_mem_write};
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [DW-1:0] rs_v, rt_v;
      rs_v = model_fwd(m.rs, m.rs_data);
      rt_v = model_fwd(m.rt, m.rt_data);
      chk("m_stall", DW'(stall), DW'(model_stall()));
      chk("m_valid", DW'(ex_valid), DW'(m.valid));
      chk("m_src1", ex_src1, m.shift ? m.imm : rs_v);
      chk("m_src2", ex_src2, m.alu_src ? m.imm : rt_v);
      chk("m_store", ex_store, rt_v);
      chk("m_ctrl", DW'(ex_ctrl), DW'(m.ctrl));
      chk("m_rd", DW'(ex_rd), DW'(m.rd));
      chk("m_flags", DW'({ex_rw, ex_mr, ex_mw}), DW'({m.rw, m.mr, m.mw} & {3{m.valid}}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rt_used = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_ctrl = 0;
    id_alu_src = 0; id_shift = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exm_wr = 0; exm_rd = 0; exm_res = 0; mwb_wr = 0; mwb_rd = 0; mwb_res = 0; flush = 0;
  endtask

  task automatic drive_op(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                          input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [3:0] ctrl,
                          input logic mr);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rt_used = 1;
    id_rs_data = rsd; id_rt_data = rtd; id_ctrl = ctrl; id_imm = 0;
    id_alu_src = 0; id_shift = 0; id_reg_write = 1; id_mem_read = mr; id_mem_write = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", DW'(ex_valid), 0);
    chk("reset_stall", DW'(stall), 0);
    chk("reset_src1", ex_src1, 0);
    cmp_en = 1;
    rst = 0;

    drive_op(3, 4, 7, 5, 7, 4'd4, 0);
    step();
    chk("pass_src1", ex_src1, 5);
    chk("pass_src2", ex_src2, 7);
    chk("pass_ctrl", DW'(ex_ctrl), 4);
    chk("pass_rw", DW'(ex_rw), 1);

    rst = 1;
    #1;
    chk("rst_mid_valid", DW'(ex_valid), 0);
    chk("rst_mid_rw", DW'(ex_rw), 0);
    chk("rst_mid_ctrl", DW'(ex_ctrl), 0);
    chk("rst_mid_stall", DW'(stall), 0);
    idle();
    step();
    rst = 0;

    drive_op(8, 1, 2, 32'h99, 0, 4'd4, 0);
    step();
    exm_wr = 1; exm_rd = 8; exm_res = 32'h11;
    mwb_wr = 1; mwb_rd = 8; mwb_res = 32'h22;
    #1;
    chk("fwd_exm_wins", ex_src1, 32'h11);
    drive_op(0, 1, 2, 32'h33, 0, 4'd4, 0);
    exm_rd = 0; mwb_rd = 0;
    step();
    chk("fwd_zero_rf", ex_src1, 32'h33);
    idle();

    drive_op(1, 0, 9, 0, 0, 4'd2, 1);
    id_rt_used = 0;
    step();
    drive_op(9, 2, 10, 32'h5, 32'h6, 4'd4, 0);
    #1;
    chk("lu_stall", DW'(stall), 1);
    step();
    chk("lu_bubble", DW'(ex_valid), 0);
    chk("lu_stall_clear", DW'(stall), 0);
    step();
    chk("lu_dep_valid", DW'(ex_valid), 1);
    chk("lu_dep_rd", DW'(ex_rd), 10);

    drive_op(1, 0, 9, 0, 0, 4'd2, 1);
    id_rt_used = 0;
    step();
    drive_op(9, 2, 10, 32'h5, 32'h6, 4'd4, 0);
    flush = 1;
    #1;
    chk("flush_no_stall", DW'(stall), 0);
    step();
    chk("flush_bubble", DW'(ex_valid), 0);
    flush = 0;

    drive_op(3, 0, 4, 32'h1, 0, 4'd12, 0);
    id_shift = 1; id_imm = 32'h140;
    step();
    chk("sll_shamt", DW'(ex_src1[10:6]), 5);
    drive_op(2, 6, 0, 32'h100, 32'h77, 4'd3, 0);
    id_alu_src = 1; id_imm = 32'h10; id_reg_write = 0; id_mem_write = 1;
    exm_wr = 1; exm_rd = 6; exm_res = 32'hAB;
    step();
    chk("sw_src2_imm", ex_src2, 32'h10);
    chk("sw_store_fwd", ex_store, 32'hAB);
    chk("sw_mw", DW'(ex_mw), 1);

    for (int i = 0; i < 500; i++) begin
      step();
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs        = AW'($urandom_range(0, 7));
      id_rt        = AW'($urandom_range(0, 7));
      id_rd        = AW'($urandom_range(0, 7));
      id_rt_used   = $urandom_range(0, 1) == 1;
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_imm       = $urandom;
      id_ctrl      = 4'($urandom_range(0, 14));
      id_alu_src   = $urandom_range(0, 1) == 1;
      id_shift     = $urandom_range(0, 3) == 0;
      id_reg_write = $urandom_range(0, 1) == 1;
      id_mem_read  = $urandom_range(0, 2) == 0;
      id_mem_write = $urandom_range(0, 3) == 0;
      exm_wr       = $urandom_range(0, 1) == 1;
      exm_rd       = AW'($urandom_range(0, 7));
      exm_res      = $urandom;
      mwb_wr       = $urandom_range(0, 1) == 1;
      mwb_rd       = AW'($urandom_range(0, 7));
      mwb_res      = $urandom;
      flush        = $urandom_range(0, 9) == 0;
    end
    step();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
